// File: rtl/delay_pipe_gen_pkg.sv
`default_nettype none
// delay_pipe_gen_pkg: shared types and helpers for the elastic delay line.
package delay_pipe_gen_pkg;

  typedef struct packed {
    logic clk;
    logic rst;
  } Data_Control_Control_T;

  localparam int unsigned C_RESET_DEFAULT = 0;

  // Occupancy counter width: clog2(depth+1), never narrower than one bit.
  function automatic int cnt_w(input int depth);
    if (depth <= 0) return 1;
    return ($clog2(depth + 1) < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_pipe_gen_stage.sv
`default_nettype none
// delay_pipe_stage: one valid/data register pair of the elastic delay line.
module delay_pipe_stage
  import delay_pipe_gen_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  Data_Control_Control_T ctrl_i,
  input  logic                  flush_i,
  input  logic                  adv_i,
  input  logic                  prev_v_i,
  input  logic [WIDTH-1:0]      prev_d_i,
  output logic                  v_o,
  output logic [WIDTH-1:0]      d_o
);

  logic             clk;
  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  assign clk = ctrl_i.clk;

  // Flush clears only the valid bit; data is loaded even behind a bubble.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (adv_i) begin
      v_d = prev_v_i;
      d_d = prev_d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (ctrl_i.rst) begin
      v_q <= 1'b0;
      d_q <= RESET;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule
`default_nettype wire

// File: rtl/delay_pipe_gen.sv
`default_nettype none
// delay_pipe_gen: elastic valid/ready delay line of DEPTH stages with flush.
// Optional occupancy counter port enabled by DELAY_PIPE_COUNT_EN.
module delay_pipe_gen
  import delay_pipe_gen_pkg::*;
#(
  parameter int               DEPTH = 2,
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET = WIDTH'(C_RESET_DEFAULT)
) (
  input  Data_Control_Control_T      ctrl_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
`ifdef DELAY_PIPE_COUNT_EN
  output logic [cnt_w(DEPTH)-1:0]    count_o,
`endif
  input  logic                       out_ready_i
);

  localparam int CNT_W = cnt_w(DEPTH);

  if (DEPTH <= 0) begin : g_passthru
    assign out_valid_o = in_valid_i & ~flush_i;
    assign in_ready_o  = out_ready_i & ~flush_i;
    assign out_data_o  = in_data_i;
`ifdef DELAY_PIPE_COUNT_EN
    assign count_o     = '0;
`endif
  end else begin : g_pipe
    logic [DEPTH-1:0] v_w;
    logic [DEPTH-1:0] adv_w;
    logic [WIDTH-1:0] d_w [DEPTH];

    // Ready ripples from the output back so a full pipe can move in and out together.
    always_comb begin
      adv_w            = '0;
      adv_w[DEPTH-1]   = ~v_w[DEPTH-1] | out_ready_i;
      for (int i = DEPTH - 2; i >= 0; i--) begin
        adv_w[i] = ~v_w[i] | adv_w[i+1];
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             prev_v_w;
      logic [WIDTH-1:0] prev_d_w;

      if (i == 0) begin : g_head
        assign prev_v_w = in_valid_i;
        assign prev_d_w = in_data_i;
      end else begin : g_link
        assign prev_v_w = v_w[i-1];
        assign prev_d_w = d_w[i-1];
      end

      delay_pipe_stage #(
        .WIDTH (WIDTH),
        .RESET (RESET)
      ) u_stage (
        .ctrl_i   (ctrl_i),
        .flush_i  (flush_i),
        .adv_i    (adv_w[i]),
        .prev_v_i (prev_v_w),
        .prev_d_i (prev_d_w),
        .v_o      (v_w[i]),
        .d_o      (d_w[i])
      );
    end

    assign in_ready_o  = adv_w[0] & ~flush_i;
    assign out_valid_o = v_w[DEPTH-1];
    assign out_data_o  = d_w[DEPTH-1];

`ifdef DELAY_PIPE_COUNT_EN
    logic             clk;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_fire_w, out_fire_w;

    assign clk        = ctrl_i.clk;
    assign in_fire_w  = fire(in_valid_i, in_ready_o);
    assign out_fire_w = fire(out_valid_o, out_ready_i);

    always_comb begin
      count_d = count_q + CNT_W'(in_fire_w) - CNT_W'(out_fire_w);
      if (flush_i) count_d = '0;
    end

    always_ff @(posedge clk) begin
      if (ctrl_i.rst) count_q <= '0;
      else            count_q <= count_d;
    end

    assign count_o = count_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_delay_pipe_gen.sv
`default_nettype none
// tb_delay_pipe_gen: directed checks of the DEPTH=3 pipe and the DEPTH=0 pass-through.
module tb_delay_pipe_gen;
  import delay_pipe_gen_pkg::*;

  logic clk;
  logic rst;
  Data_Control_Control_T ctrl;

  logic       flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic       pt_flush, pt_in_valid, pt_in_ready, pt_out_valid, pt_out_ready;
  logic [7:0] pt_in_data, pt_out_data;
`ifdef DELAY_PIPE_COUNT_EN
  logic [1:0] count;
  logic       pt_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  assign ctrl.clk = clk;
  assign ctrl.rst = rst;

  delay_pipe_gen #(.DEPTH(3), .WIDTH(8), .RESET(8'h5A)) u_dut (
    .ctrl_i      (ctrl),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
`ifdef DELAY_PIPE_COUNT_EN
    .count_o     (count),
`endif
    .out_ready_i (out_ready)
  );

  delay_pipe_gen #(.DEPTH(0), .WIDTH(8), .RESET(8'h5A)) u_pt (
    .ctrl_i      (ctrl),
    .flush_i     (pt_flush),
    .in_valid_i  (pt_in_valid),
    .in_data_i   (pt_in_data),
    .in_ready_o  (pt_in_ready),
    .out_valid_o (pt_out_valid),
    .out_data_o  (pt_out_data),
`ifdef DELAY_PIPE_COUNT_EN
    .count_o     (pt_count),
`endif
    .out_ready_i (pt_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef DELAY_PIPE_COUNT_EN
    check_eq(tag, 32'(count), exp);
`else
    if (tag.len() < 0) $display("%0d", exp);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    pt_flush = 1'b0; pt_in_valid = 1'b0; pt_in_data = 8'h00; pt_out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 32'h5A);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_cnt("rst_count", 0);

    // Fill / drain
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    check_eq("fill_early_valid", 32'(out_valid), 0);
    in_data = 8'h33; step();
    in_valid = 1'b0;
    check_eq("fill_v0", 32'(out_valid), 1);
    check_eq("fill_d0", 32'(out_data), 32'h11);
    check_cnt("fill_count_peak", 3);
    step();
    check_eq("fill_d1", 32'(out_data), 32'h22);
    step();
    check_eq("fill_d2", 32'(out_data), 32'h33);
    step();
    check_eq("drain_valid", 32'(out_valid), 0);
    check_cnt("drain_count", 0);

    // Full stall then release
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'hA0 + 8'(k);
      #1;
      check_eq("stall_accept_ready", 32'(in_ready), 1);
      step();
    end
    in_data = 8'hA3;
    #1;
    check_eq("stall_full_ready", 32'(in_ready), 0);
    check_eq("stall_full_data", 32'(out_data), 32'hA0);
    check_cnt("stall_full_count", 3);
    step();
    check_eq("stall_hold_data", 32'(out_data), 32'hA0);
    check_eq("stall_hold_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    check_eq("release_ready_same_cycle", 32'(in_ready), 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) in_data = 8'hA4;
      if (k == 2) in_valid = 1'b0;
      #1;
      check_eq("release_valid", 32'(out_valid), 1);
      check_eq("release_data", 32'(out_data), 32'hA0 + 32'(k));
      if (k < 2) check_cnt("release_count", 3);
      step();
    end
    check_eq("release_empty", 32'(out_valid), 0);

    // Bubble collapse
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 8'h06;
    #1;
    check_eq("bubble_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0; step();
    check_eq("bubble_valid", 32'(out_valid), 1);
    check_eq("bubble_data", 32'(out_data), 32'h05);
    check_eq("bubble_in_ready", 32'(in_ready), 1);
    check_cnt("bubble_count", 2);
    step();
    check_eq("bubble_hold_data", 32'(out_data), 32'h05);
    check_eq("bubble_hold_ready", 32'(in_ready), 1);
    check_cnt("bubble_hold_count", 2);

    // Flush with a full pipe and an offered beat
    in_valid = 1'b1; in_data = 8'h07; step();
    check_cnt("preflush_count", 3);
    in_data = 8'hFF; flush = 1'b1; out_ready = 1'b1;
    #1;
    check_eq("flush_in_ready", 32'(in_ready), 0);
    step();
    flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    check_eq("flush_out_valid", 32'(out_valid), 0);
    check_cnt("flush_count", 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("flush_no_ghost", 32'(out_valid), 0);
    end

    // Reset together with flush mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h31; step();
    in_data = 8'h32; step();
    in_valid = 1'b0; step();
    check_eq("midrst_pre_data", 32'(out_data), 32'h31);
    rst = 1'b1; flush = 1'b1; step();
    rst = 1'b0; flush = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 0);
    check_eq("midrst_data", 32'(out_data), 32'h5A);
    check_eq("midrst_in_ready", 32'(in_ready), 1);
    check_cnt("midrst_count", 0);

    // DEPTH=0 pass-through
    pt_in_valid = 1'b1; pt_in_data = 8'h7E; pt_out_ready = 1'b0;
    #1;
    check_eq("pt_valid", 32'(pt_out_valid), 1);
    check_eq("pt_data", 32'(pt_out_data), 32'h7E);
    check_eq("pt_ready_low", 32'(pt_in_ready), 0);
    pt_out_ready = 1'b1;
    #1;
    check_eq("pt_ready_high", 32'(pt_in_ready), 1);
    pt_flush = 1'b1;
    #1;
    check_eq("pt_flush_valid", 32'(pt_out_valid), 0);
    check_eq("pt_flush_ready", 32'(pt_in_ready), 0);
`ifdef DELAY_PIPE_COUNT_EN
    check_eq("pt_count", 32'(pt_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
